// File: rtl/imem_dmem_arbiter.sv
// ============================================================================
//  Module   : imem_dmem_arbiter
//  Brief    : Shares one single-port synchronous unified RAM between the fetch
//             stage and the load/store unit. The LSU has priority. Read data
//             (1-cycle latency) is routed back to whichever requester issued
//             the read. Fetch data still in flight is dropped on a flush.
//             Optional macro ARB_FAIR_EN: after MAX_D_STREAK consecutive LSU
//             grants while fetch waits, fetch is forced through for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              if_valid,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    input  logic              if_flush,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    // load/store port
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    // pipeline
    output logic              stall,
    // RAM side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF    = 2'd1,
        OWN_DLOAD = 2'd2
    } owner_t;

    owner_t      resp_owner;
    owner_t      resp_owner_next;
    logic        if_req;
    logic        force_if;
    logic        d_grant;
    logic        if_grant;
    logic [31:0] if_rdata_hold;
    logic [31:0] d_rdata_hold;

    // Only the word index inside the RAM is meaningful; the rest is dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2],  d_addr[1:0]};

    // A fetch raised together with a flush is already stale and never competes.
    assign if_req = if_valid & ~if_flush;

`ifdef ARB_FAIR_EN
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    logic [STREAK_W-1:0] streak;

    // Count LSU wins that kept a live fetch waiting; reset once fetch is served or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (!if_req || if_grant) begin
            streak <= '0;
        end else if (d_grant && streak != STREAK_W'(MAX_D_STREAK)) begin
            streak <= streak + 1'b1;
        end
    end

    assign force_if = if_req & (streak == STREAK_W'(MAX_D_STREAK));
`else
    logic unused_streak_param;
    assign unused_streak_param = (MAX_D_STREAK != 0);
    assign force_if            = 1'b0;
`endif

    // Grant selection and RAM request mux; everything idles at zero without a grant.
    always_comb begin
        d_grant         = d_valid & ~force_if;
        if_grant        = if_req & ~d_grant;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        resp_owner_next = OWN_NONE;
        if (d_grant) begin
            mem_en          = 1'b1;
            mem_we          = d_we;
            mem_addr        = d_addr[ADDR_W+1:2];
            mem_wdata       = d_wdata;
            resp_owner_next = d_we ? OWN_NONE : OWN_DLOAD;
        end else if (if_grant) begin
            mem_en          = 1'b1;
            mem_addr        = if_addr[ADDR_W+1:2];
            resp_owner_next = OWN_IF;
        end
    end

    assign if_ready = if_grant;
    assign d_ready  = d_grant;
    assign stall    = (if_valid & ~if_grant & ~if_flush) | (d_valid & ~d_grant);

    // Remember who owns the RAM read data arriving next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_owner <= OWN_NONE;
        end else begin
            resp_owner <= resp_owner_next;
        end
    end

    // A flush turns an arriving instruction into a bubble.
    assign if_rvalid = (resp_owner == OWN_IF) & ~if_flush;
    assign d_rvalid  = (resp_owner == OWN_DLOAD);

    // Hold copies of the last delivered words so rdata stays put between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_hold <= '0;
            d_rdata_hold  <= '0;
        end else begin
            if (if_rvalid) if_rdata_hold <= mem_rdata;
            if (d_rvalid)  d_rdata_hold  <= mem_rdata;
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_hold;
    assign d_rdata  = d_rvalid  ? mem_rdata : d_rdata_hold;

endmodule

`default_nettype wire
